// File: rtl/plru_tracker_pkg.sv
// plru_tracker_pkg
// Shared constants and types for the per-set tree pseudo-LRU tracker.
//   PLRU_ASSOC / PLRU_SETS : default ways per set / number of sets
//   plru_t                 : PLRU bit vector of one set (ASSOC-1 tree nodes)
//   plru_state_t           : tracker FSM state encoding
package plru_tracker_pkg;

  localparam int PLRU_ASSOC = 8;
  localparam int PLRU_SETS  = 16;

  typedef logic [PLRU_ASSOC-2:0] plru_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    CLEAR  = 2'd2
  } plru_state_t;

endpackage

// File: rtl/plru_tracker_if.sv
// plru_tracker_if
// Access / clear / lookup bundle between the tag-hit logic (master) and the
// PLRU tracker (slave).
//   acc_valid, acc_set, acc_way : access request (hit or fill)
//   acc_ready                   : tracker can accept an access this cycle
//   clr_req                     : start a full clear of all sets
//   busy                        : update or clear in progress
//   lk_set                      : set looked up for eviction
//   lru_bits                    : registered PLRU bits of lk_set
interface plru_tracker_if #(
  parameter int ASSOC = plru_tracker_pkg::PLRU_ASSOC,
  parameter int SETS  = plru_tracker_pkg::PLRU_SETS
);

  localparam int WAY_W = $clog2(ASSOC);
  localparam int SET_W = $clog2(SETS);

  logic             acc_valid;
  logic             acc_ready;
  logic [SET_W-1:0] acc_set;
  logic [WAY_W-1:0] acc_way;
  logic             clr_req;
  logic             busy;
  logic [SET_W-1:0] lk_set;
  logic [ASSOC-2:0] lru_bits;

  modport master (
    output acc_valid, acc_set, acc_way, clr_req, lk_set,
    input  acc_ready, busy, lru_bits
  );

  modport slave (
    input  acc_valid, acc_set, acc_way, clr_req, lk_set,
    output acc_ready, busy, lru_bits
  );

endinterface

// File: rtl/plru_path_update.sv
// plru_path_update
// Combinational tree-PLRU touch: every node on the root-to-leaf path of
// `way` is set to the corresponding way bit, so it points away from the
// touched way. Nodes off the path keep their old value.
//   old_bits : current PLRU bits of the set
//   way      : touched way
//   new_bits : updated PLRU bits
module plru_path_update #(
  parameter int ASSOC = 8
) (
  input  logic [ASSOC-2:0]         old_bits,
  input  logic [$clog2(ASSOC)-1:0] way,
  output logic [ASSOC-2:0]         new_bits
);

  localparam int WAY_W = $clog2(ASSOC);

  // Level i's path node sits at (2^i - 1) + (way's top i bits); comparing
  // against every node keeps all bit selects constant.
  always_comb begin
    new_bits = old_bits;
    for (int i = 0; i < WAY_W; i++) begin
      for (int n = 0; n < ASSOC - 1; n++) begin
        if (n == ((1 << i) - 1 + (int'(way) >> (WAY_W - i)))) begin
          new_bits[n] = way[WAY_W-1-i];
        end
      end
    end
  end

endmodule

// File: rtl/plru_tracker.sv
// plru_tracker
// Per-set tree pseudo-LRU state store. Each accepted access rewrites the
// PLRU row of its set one cycle later (read-modify-write); clr_req zeroes
// every row, one per cycle. The row of lk_set is registered onto lru_bits
// every cycle, independent of the FSM.
//
// Optional feature macro PLRU_BYPASS_EN: when defined, a row written at an
// edge that matches lk_set is forwarded straight into lru_bits at that same
// edge. Undefined, lru_bits returns the pre-write contents.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : plru_tracker_if slave modport (access, clear, lookup)
//
// state  | meaning
// IDLE   | ready for an access or a clear request
// UPDATE | writing the touched path into the latched set's row
// CLEAR  | zeroing row clr_cnt, one row per cycle
module plru_tracker
  import plru_tracker_pkg::*;
#(
  parameter int ASSOC = PLRU_ASSOC,
  parameter int SETS  = PLRU_SETS
) (
  input logic           clk,
  input logic           rst_n,
  plru_tracker_if.slave bus
);

  localparam int WAY_W = $clog2(ASSOC);
  localparam int SET_W = $clog2(SETS);

  plru_state_t      state;
  logic [SET_W-1:0] upd_set;
  logic [WAY_W-1:0] upd_way;
  logic [SET_W-1:0] clr_cnt;
  logic             ready_q;
  logic             busy_q;

  logic [ASSOC-2:0] rows [SETS];
  logic [ASSOC-2:0] upd_bits;
  logic [ASSOC-2:0] lru_q;

  logic             wr_en;
  logic [SET_W-1:0] wr_set;
  logic [ASSOC-2:0] wr_data;

  plru_path_update #(.ASSOC(ASSOC)) u_path_update (
    .old_bits (rows[upd_set]),
    .way      (upd_way),
    .new_bits (upd_bits)
  );

  always_comb begin
    wr_en   = (state == UPDATE) || (state == CLEAR);
    wr_set  = (state == UPDATE) ? upd_set : clr_cnt;
    wr_data = (state == UPDATE) ? upd_bits : '0;
  end

  // acc_ready / busy are registered alongside the state so they reflect the
  // state of the current cycle with no decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      upd_set <= '0;
      upd_way <= '0;
      clr_cnt <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (bus.acc_valid) begin
            state   <= UPDATE;
            upd_set <= bus.acc_set;
            upd_way <= bus.acc_way;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        UPDATE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        CLEAR: begin
          if (clr_cnt == SET_W'(SETS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        rows[s] <= '0;
      end
    end else if (wr_en) begin
      rows[wr_set] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else begin
`ifdef PLRU_BYPASS_EN
      if (wr_en && (wr_set == bus.lk_set)) begin
        lru_q <= wr_data;
      end else begin
        lru_q <= rows[bus.lk_set];
      end
`else
      lru_q <= rows[bus.lk_set];
`endif
    end
  end

  assign bus.acc_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.lru_bits  = lru_q;

endmodule
